bch_chien_serial: RTL and testbench
===================================

Name: bch_chien_serial

Overview:
- Serial Chien-search and correction stage for the BCH(15,7) double-error-correcting decoder over GF(2^4).
- Sits directly downstream of the inversionless Berlekamp-Massey stage. It consumes error-locator coefficients lambda0..lambda2 together with the received 15-bit codeword.
- It evaluates the locator at one field element per cycle, flips the erroneous bits, and flags uncorrectable words.

Parameters:
- N, 15, codeword length and number of search cycles. Fixed for this code; not meant to be overridden.
- M, 4, field width in bits. GF(2^4), primitive polynomial x^4+x+1, alpha = 4'b0010.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  locator and codeword present
- in_ready  output  1  block can accept a new job
- locator0  input  4  lambda0 (constant term of Lambda(x))
- locator1  input  4  lambda1
- locator2  input  4  lambda2
- codeword_in  input  15  received word; bit j is the coefficient of x^j
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- data_out  output  15  corrected codeword
- err_vec  output  15  positions found in error
- err_cnt  output  2  number of roots found (0..2)
- uncorrectable  output  1  decoding failure

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE, counter = 0.
  - All internal registers clear.
  - in_ready=0 while reset is asserted, 1 in the first cycle after release.
  - out_valid=0, data_out=0, err_vec=0, err_cnt=0, uncorrectable=0.
  - Reset mid-search abandons the job; no partial result is ever emitted.
- FSM states: IDLE -> SEARCH -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready, register lambda0, codeword_in, t1=lambda1, t2=lambda2. Clear the root accumulator and err_vec. Go to SEARCH with j=0.
- SEARCH (exactly 15 cycles, j = 0..14):
  - Combinationally compute s = lambda0 ^ t1 ^ t2, which equals Lambda(alpha^-j).
  - If s==0: set err_vec[j] and increment the root count, saturating at 3 internally.
  - Update t1 <= t1*alpha^14 (alpha^-1) and t2 <= t2*alpha^13 (alpha^-2). Both are constant GF multipliers with pure XOR logic.
  - j==14: go to DONE.
- DONE:
  - out_valid=1; data_out, err_vec, err_cnt and uncorrectable are held stable.
  - When out_ready=1, go to IDLE.
  - in_ready=0 throughout DONE; no overlap with the next job.
- Latency: a job accepted at cycle 0 produces out_valid=1 at cycle 16 (15 SEARCH cycles plus 1). Maximum throughput is one job per 17 cycles with out_ready tied high.
- Degree: deg = 2 if lambda2!=0; 1 if lambda2==0 and lambda1!=0; else 0.
- uncorrectable=1 if either:
  - lambda0==0, or
  - the root count != deg.
- Result on success:
  - data_out = codeword_in ^ err_vec.
  - err_cnt = root count.
  - Zero-error case: lambda1=lambda2=0, lambda0!=0 gives err_vec=0, err_cnt=0, data_out=codeword_in.
- Result on failure:
  - data_out = codeword_in, unmodified.
  - err_vec is forced to 0.
  - err_cnt = min(root count, 3) when lambda0!=0, and 0 when lambda0==0.
- in_valid while not in IDLE is ignored. Input ports are sampled only on the accept edge.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset, then accept lambda=(0001,0000,0000) with codeword 15'h1234 -> at cycle 16: out_valid=1, data_out=15'h1234, err_vec=0, err_cnt=0, uncorrectable=0.
- Single error at position 3: lambda=(0001,1000,0000), codeword 15'h0008 -> err_vec=15'h0008, err_cnt=1, data_out=15'h0000, uncorrectable=0.
- Double error at positions 0 and 5: lambda=(0001,0111,0110), codeword 15'h7FFF -> err_vec=15'h0021, err_cnt=2, data_out=15'h7FDE, uncorrectable=0.
- Double root: lambda=(0001,0000,0001), i.e. (1+x)^2 -> single root at j=0, deg 2 -> uncorrectable=1, err_vec=0, data_out=codeword_in. Also lambda0=0000 -> uncorrectable=1, err_cnt=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises -> outputs stable and in_ready=0 throughout. Pulse in_valid during SEARCH -> ignored. out_ready=1 -> in_ready=1 on the next cycle.
- Assert rst_n=0 at SEARCH j=7 -> all outputs 0 immediately. After release a new job completes correctly with no residue from the aborted one.

Source files
------------

// File: rtl/bch_chien_serial.sv
// Serial Chien search and correction for BCH(15,7) over GF(2^4) (x^4+x+1).
// The locator is evaluated at alpha^-j for j = 0..14, one point per cycle.
// A root at alpha^-j marks bit j of the codeword as erroneous.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for a job; in_ready high once reset has released
// S_SEARCH | 15 evaluation cycles, r_j = 0..14
// S_DONE   | result held on the outputs until out_ready
module bch_chien_serial #(
  parameter int N = 15,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] locator0,
  input  logic [M-1:0] locator1,
  input  logic [M-1:0] locator2,
  input  logic [N-1:0] codeword_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic [N-1:0] err_vec,
  output logic [1:0]   err_cnt,
  output logic         uncorrectable
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] J_LAST = 4'd14;

  // Multiply by alpha^-1 = alpha^3 + 1: a right shift with the dropped
  // bit folded back into bits 3 and 0.
  function automatic logic [3:0] mul_ainv(input logic [3:0] v);
    return {v[0], v[3], v[2], v[1] ^ v[0]};
  endfunction

  // Multiply by alpha^-2, two alpha^-1 steps collapsed into XOR logic.
  function automatic logic [3:0] mul_ainv2(input logic [3:0] v);
    return mul_ainv(mul_ainv(v));
  endfunction

  logic [1:0]   r_state;
  logic         r_in_ready;
  logic [3:0]   r_j;
  logic [M-1:0] r_lam0;
  logic [M-1:0] r_t1;
  logic [M-1:0] r_t2;
  logic [N-1:0] r_cw;
  logic [1:0]   r_deg;
  logic [1:0]   r_cnt;
  logic [N-1:0] r_err;
  logic [N-1:0] r_data_out;
  logic [N-1:0] r_err_vec;
  logic [1:0]   r_err_cnt;
  logic         r_unc;

  logic         w_accept;
  logic [M-1:0] w_s;
  logic         w_hit;
  logic [1:0]   w_cnt_nxt;
  logic [N-1:0] w_err_nxt;
  logic         w_unc;
  logic [1:0]   w_deg_in;

  assign w_accept = in_valid & r_in_ready;

  // Locator value at alpha^-j and the root bookkeeping it feeds.
  always_comb begin
    w_s       = r_lam0 ^ r_t1 ^ r_t2;
    w_hit     = (w_s == '0);
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    if (w_hit) begin
      w_err_nxt = r_err | (N'(1) << r_j);
      if (r_cnt != 2'd3) w_cnt_nxt = r_cnt + 2'd1;
    end
    w_unc = (r_lam0 == '0) || (w_cnt_nxt != r_deg);
  end

  // Degree of the incoming locator, captured with the job.
  always_comb begin
    w_deg_in = 2'd0;
    if (locator2 != '0)      w_deg_in = 2'd2;
    else if (locator1 != '0) w_deg_in = 2'd1;
  end

  // Job sequencing, search datapath and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_j        <= '0;
      r_lam0     <= '0;
      r_t1       <= '0;
      r_t2       <= '0;
      r_cw       <= '0;
      r_deg      <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_data_out <= '0;
      r_err_vec  <= '0;
      r_err_cnt  <= '0;
      r_unc      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state    <= S_SEARCH;
            r_in_ready <= 1'b0;
            r_j        <= '0;
            r_lam0     <= locator0;
            r_t1       <= locator1;
            r_t2       <= locator2;
            r_cw       <= codeword_in;
            r_deg      <= w_deg_in;
            r_cnt      <= '0;
            r_err      <= '0;
            r_data_out <= '0;
            r_err_vec  <= '0;
            r_err_cnt  <= '0;
            r_unc      <= 1'b0;
          end
        end
        S_SEARCH: begin
          r_t1  <= mul_ainv(r_t1);
          r_t2  <= mul_ainv2(r_t2);
          r_cnt <= w_cnt_nxt;
          r_err <= w_err_nxt;
          r_j   <= r_j + 4'd1;
          if (r_j == J_LAST) begin
            r_state    <= S_DONE;
            r_unc      <= w_unc;
            r_data_out <= w_unc ? r_cw : (r_cw ^ w_err_nxt);
            r_err_vec  <= w_unc ? '0 : w_err_nxt;
            r_err_cnt  <= (r_lam0 == '0) ? 2'd0 : w_cnt_nxt;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = (r_state == S_DONE);
  assign data_out      = r_data_out;
  assign err_vec       = r_err_vec;
  assign err_cnt       = r_err_cnt;
  assign uncorrectable = r_unc;

endmodule

// File: tb/tb_bch_chien_serial.sv
// Directed bench for bch_chien_serial: table of hand-computed jobs plus
// backpressure and mid-search reset sequences.
module tb_bch_chien_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  locator0 = '0;
  logic [3:0]  locator1 = '0;
  logic [3:0]  locator2 = '0;
  logic [14:0] codeword_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [14:0] data_out;
  logic [14:0] err_vec;
  logic [1:0]  err_cnt;
  logic        uncorrectable;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  l0, l1, l2;
    logic [14:0] cw;
    logic [14:0] exp_data;
    logic [14:0] exp_err;
    logic [1:0]  exp_cnt;
    logic        exp_unc;
  } vec_t;

  vec_t vecs[9];

  bch_chien_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .locator0(locator0), .locator1(locator1), .locator2(locator2),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_vec(err_vec), .err_cnt(err_cnt),
    .uncorrectable(uncorrectable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_ready_wait"}, in_ready, 1);
  endtask

  // Present a job for one accept edge, then scramble the inputs.
  task automatic start(input vec_t v, input string tag);
    wait_ready(tag);
    locator0 = v.l0; locator1 = v.l1; locator2 = v.l2; codeword_in = v.cw;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    locator0 = 4'hF; locator1 = 4'hA; locator2 = 4'h5; codeword_in = 15'h2AAA;
  endtask

  // Called right after the accept edge: counts edges to out_valid and
  // checks the result. Accept cycle 0 -> out_valid in cycle 16, i.e.
  // 15 edges after the accept edge.
  task automatic finish(input vec_t v, input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_latency"}, n, 15);
    chk({tag, "_data"}, data_out, v.exp_data);
    chk({tag, "_errvec"}, err_vec, v.exp_err);
    chk({tag, "_errcnt"}, err_cnt, v.exp_cnt);
    chk({tag, "_unc"}, uncorrectable, v.exp_unc);
    chk({tag, "_inready_done"}, in_ready, 0);
  endtask

  initial begin
    //        l0     l1     l2     cw        data      err       cnt  unc
    vecs[0] = '{4'h1, 4'h0, 4'h0, 15'h1234, 15'h1234, 15'h0000, 2'd0, 1'b0};
    vecs[1] = '{4'h1, 4'h8, 4'h0, 15'h0008, 15'h0000, 15'h0008, 2'd1, 1'b0};
    vecs[2] = '{4'h1, 4'h7, 4'h6, 15'h7FFF, 15'h7FDE, 15'h0021, 2'd2, 1'b0};
    vecs[3] = '{4'h1, 4'h0, 4'h1, 15'h5A5A, 15'h5A5A, 15'h0000, 2'd1, 1'b1};
    vecs[4] = '{4'h0, 4'h5, 4'h3, 15'h1111, 15'h1111, 15'h0000, 2'd0, 1'b1};
    vecs[5] = '{4'h1, 4'h9, 4'h0, 15'h4000, 15'h0000, 15'h4000, 2'd1, 1'b0};
    vecs[6] = '{4'h1, 4'h6, 4'h8, 15'h0006, 15'h0000, 15'h0006, 2'd2, 1'b0};
    vecs[7] = '{4'h8, 4'h1, 4'h0, 15'h0000, 15'h1000, 15'h1000, 2'd1, 1'b0};
    vecs[8] = '{4'h0, 4'h0, 4'h0, 15'h0F0F, 15'h0F0F, 15'h0000, 2'd0, 1'b1};

    // Reset state
    cyc();
    cyc();
    chk("rst_inready", in_ready, 0);
    chk("rst_outvalid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_errvec", err_vec, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_unc", uncorrectable, 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("rel_inready", in_ready, 1);

    // Table-driven jobs, out_ready held high
    for (int i = 0; i < 9; i++) begin
      start(vecs[i], $sformatf("v%0d", i));
      finish(vecs[i], $sformatf("v%0d", i));
      cyc();
      chk($sformatf("v%0d_inready_after", i), in_ready, 1);
      chk($sformatf("v%0d_outvalid_after", i), out_valid, 0);
    end

    // Backpressure plus an in_valid pulse during SEARCH
    out_ready = 1'b0;
    start(vecs[2], "bp");
    cyc();
    cyc();
    locator0 = vecs[0].l0; locator1 = vecs[0].l1; locator2 = vecs[0].l2;
    codeword_in = vecs[0].cw;
    in_valid = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 40) begin
        cyc();
        n++;
      end
      chk("bp_latency", n, 11);
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      chk($sformatf("bp_hold%0d_data", k), data_out, vecs[2].exp_data);
      chk($sformatf("bp_hold%0d_err", k), err_vec, vecs[2].exp_err);
      chk($sformatf("bp_hold%0d_cnt", k), err_cnt, vecs[2].exp_cnt);
      chk($sformatf("bp_hold%0d_inready", k), in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_release_inready", in_ready, 1);
    chk("bp_release_outvalid", out_valid, 0);
    cyc();
    cyc();
    chk("bp_no_ghost_job", out_valid, 0);

    // Reset during SEARCH at j=7
    start(vecs[2], "ab");
    for (int k = 0; k < 7; k++) cyc();
    rst_n = 1'b0;
    #1;
    chk("ab_outvalid", out_valid, 0);
    chk("ab_inready", in_ready, 0);
    chk("ab_data", data_out, 0);
    chk("ab_errvec", err_vec, 0);
    chk("ab_errcnt", err_cnt, 0);
    chk("ab_unc", uncorrectable, 0);
    cyc();
    cyc();
    chk("ab_hold_outvalid", out_valid, 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("ab_rel_inready", in_ready, 1);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) chk("ab_partial_result", out_valid, 0);
      cyc();
    end
    start(vecs[6], "post");
    finish(vecs[6], "post");
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
